// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: IDLE -> FETCH -> HOLD loop with a bounded memory wait. ins_valid rises 1 cycle after imem_ready.
// stall freezes HOLD. Optional HALT on ins 32'h0000000C when FETCH_HALT_EN is defined.
module fetch_controller #(
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              TIMEOUT  = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stall,
  input  logic            PCSrc,
  input  logic [31:0]     sl2,
  input  logic            imem_ready,
  input  logic [31:0]     imem_rdata,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     ins,
  output logic            ins_valid,
  output logic            halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_HOLD,
    S_ERR
`ifdef FETCH_HALT_EN
    , S_HALT
`endif
  } state_t;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);
  localparam logic [4:0]      WAIT_MAX = 5'(TIMEOUT);
`ifdef FETCH_HALT_EN
  localparam logic [31:0]     HALT_INS = 32'h0000000C;
`endif

  state_t          state, state_d;
  logic [PC_W-1:0] pc_d;
  logic [31:0]     ins_d;
  logic            vld_d;
  logic [3:0]      wcnt, wcnt_d;
  logic [4:0]      wait_next;
  logic [PC_W-1:0] branch_off;

  // Only the low PC_W bits of the offset matter; PC arithmetic wraps.
  logic unused_sl2;
  assign unused_sl2 = ^sl2;

  assign imem_addr  = pc;
  assign wait_next  = {1'b0, wcnt} + 5'd1;
  assign branch_off = PCSrc ? sl2[PC_W-1:0] : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      ins       <= '0;
      ins_valid <= 1'b0;
      wcnt      <= '0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      ins       <= ins_d;
      ins_valid <= vld_d;
      wcnt      <= wcnt_d;
    end
  end

  always_comb begin
    state_d  = state;
    pc_d     = pc;
    ins_d    = ins;
    vld_d    = ins_valid;
    wcnt_d   = wcnt;
    imem_req = 1'b0;
    halted   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          wcnt_d  = '0;
        end
      end
      S_FETCH: begin
        imem_req = 1'b1;
        // A response on the final allowed cycle wins over the timeout.
        if (imem_ready) begin
          ins_d   = imem_rdata;
          vld_d   = 1'b1;
          state_d = S_HOLD;
        end else begin
          wcnt_d = wait_next[3:0];
          if (wait_next == WAIT_MAX) begin
            state_d = S_ERR;
          end
        end
      end
      S_HOLD: begin
        if (!stall) begin
`ifdef FETCH_HALT_EN
          if (ins == HALT_INS) begin
            state_d = S_HALT;
          end else
`endif
          begin
            pc_d    = pc + PC_STEP + branch_off;
            vld_d   = 1'b0;
            wcnt_d  = '0;
            state_d = S_FETCH;
          end
        end
      end
      S_ERR: begin
        halted = 1'b1;
        vld_d  = 1'b0;
      end
`ifdef FETCH_HALT_EN
      S_HALT: begin
        halted = 1'b1;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller: vector table plus timeout, async reset and halt sequences.
module tb_fetch_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        stall = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] sl2 = '0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [9:0]  pc;
  logic [31:0] ins;
  logic        ins_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  fetch_controller dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .stall      (stall),
    .PCSrc      (PCSrc),
    .sl2        (sl2),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, st, sl, ps;
    logic [31:0] s2;
    logic        rdy;
    logic [31:0] rd;
    logic        req;
    logic [9:0]  p;
    logic [31:0] i;
    logic        v, h;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic sl, input logic ps,
                              input logic [31:0] s2, input logic rdy, input logic [31:0] rd,
                              input logic req, input logic [9:0] p, input logic [31:0] i,
                              input logic v, input logic h);
    vec_t r;
    r.rst = rst; r.st = st; r.sl = sl; r.ps = ps; r.s2 = s2; r.rdy = rdy; r.rd = rd;
    r.req = req; r.p = p; r.i = i; r.v = v; r.h = h;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic [9:0] p,
                         input logic [31:0] i, input logic v, input logic h);
    chk({tag, ".imem_req"},  32'(imem_req),  32'(req));
    chk({tag, ".pc"},        32'(pc),        32'(p));
    chk({tag, ".imem_addr"}, 32'(imem_addr), 32'(p));
    chk({tag, ".ins"},       ins,            i);
    chk({tag, ".ins_valid"}, 32'(ins_valid), 32'(v));
    chk({tag, ".halted"},    32'(halted),    32'(h));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst st sl ps sl2           rdy rdata          req pc      ins           v  h
    vq.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h0,         0, 10'h000, 32'h0,        0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         0, 10'h000, 32'h0,        0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'hDEAD,      0, 10'h000, 32'h0,        0, 0));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,         1, 10'h000, 32'h0,        0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h11111111,  0, 10'h000, 32'h11111111, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 10'h004, 32'h11111111, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h11111111,  0, 10'h004, 32'h11111111, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 10'h008, 32'h11111111, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h11111111,  0, 10'h008, 32'h11111111, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 10'h00C, 32'h11111111, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h22222222,  0, 10'h00C, 32'h22222222, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 10'h010, 32'h22222222, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h33333333,  0, 10'h010, 32'h33333333, 1, 0));
    vq.push_back(mk(1, 0, 0, 1, 32'h20,       0, 32'h0,         1, 10'h034, 32'h33333333, 0, 0));
    vq.push_back(mk(1, 0, 1, 1, 32'h100,      0, 32'h0,         1, 10'h034, 32'h33333333, 0, 0));
    vq.push_back(mk(1, 0, 0, 1, 32'h100,      1, 32'h44444444,  0, 10'h034, 32'h44444444, 1, 0));
    vq.push_back(mk(1, 0, 1, 1, 32'h40,       0, 32'h0,         0, 10'h034, 32'h44444444, 1, 0));
    vq.push_back(mk(1, 1, 1, 1, 32'h40,       1, 32'hBAD0BAD0,  0, 10'h034, 32'h44444444, 1, 0));
    vq.push_back(mk(1, 0, 1, 1, 32'h40,       0, 32'h0,         0, 10'h034, 32'h44444444, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h40,       0, 32'h0,         1, 10'h038, 32'h44444444, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h55555555,  0, 10'h038, 32'h55555555, 1, 0));
    vq.push_back(mk(1, 0, 1, 1, 32'h40,       0, 32'h0,         0, 10'h038, 32'h55555555, 1, 0));
    vq.push_back(mk(1, 0, 0, 1, 32'h40,       0, 32'h0,         1, 10'h07C, 32'h55555555, 0, 0));
    vq.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,         1, 10'h07C, 32'h55555555, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h66666666,  0, 10'h07C, 32'h66666666, 1, 0));
    vq.push_back(mk(1, 0, 0, 1, 32'hFFFFF37C, 0, 32'h0,         1, 10'h3FC, 32'h66666666, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        1, 32'h77777777,  0, 10'h3FC, 32'h77777777, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 32'h0,        0, 32'h0,         1, 10'h000, 32'h77777777, 0, 0));

    #1 reset = 1'b0;
    #1 chk_out("por", 0, 10'h000, 32'h0, 0, 0);

    foreach (vq[k]) begin
      reset      = vq[k].rst;
      start      = vq[k].st;
      stall      = vq[k].sl;
      PCSrc      = vq[k].ps;
      sl2        = vq[k].s2;
      imem_ready = vq[k].rdy;
      imem_rdata = vq[k].rd;
      step();
      chk_out($sformatf("vec%0d", k), vq[k].req, vq[k].p, vq[k].i, vq[k].v, vq[k].h);
    end

    // Timeout: 15 FETCH cycles without ready ends in ERR, which is terminal.
    start = 1'b0; stall = 1'b0; PCSrc = 1'b0; sl2 = '0; imem_ready = 1'b0;
    repeat (14) step();
    chk_out("tmo14", 1, 10'h000, 32'h77777777, 0, 0);
    step();
    chk_out("tmo15", 0, 10'h000, 32'h77777777, 0, 1);
    imem_ready = 1'b1; start = 1'b1;
    repeat (3) step();
    chk_out("err_terminal", 0, 10'h000, 32'h77777777, 0, 1);

    // Ready on the 15th cycle beats the timeout.
    imem_ready = 1'b0; start = 1'b0;
    reset = 1'b0;
    #2 chk_out("rst_err", 0, 10'h000, 32'h0, 0, 0);
    step();
    reset = 1'b1; start = 1'b1;
    step();
    chk_out("restart_a", 1, 10'h000, 32'h0, 0, 0);
    start = 1'b0;
    repeat (14) step();
    imem_ready = 1'b1; imem_rdata = 32'hABCD0123;
    step();
    chk_out("late_rdy", 0, 10'h000, 32'hABCD0123, 1, 0);

    // Asynchronous reset in the middle of a FETCH at pc 0x008.
    imem_ready = 1'b0;
    step();
    chk_out("c_fetch4", 1, 10'h004, 32'hABCD0123, 0, 0);
    imem_ready = 1'b1; imem_rdata = 32'h00000099;
    step();
    imem_ready = 1'b0;
    step();
    chk_out("pre_rst", 1, 10'h008, 32'h00000099, 0, 0);
    imem_ready = 1'b1; imem_rdata = 32'h12345678;
    reset = 1'b0;
    #2 chk_out("async_rst", 0, 10'h000, 32'h0, 0, 0);
    step();
    reset = 1'b1;
    repeat (2) step();
    chk_out("idle_ignore_rdy", 0, 10'h000, 32'h0, 0, 0);
    imem_ready = 1'b0; start = 1'b1;
    step();
    chk_out("restart_b", 1, 10'h000, 32'h0, 0, 0);
    start = 1'b0;

    // Instruction 0x0000000C: halts only when the feature is built in.
    imem_ready = 1'b1; imem_rdata = 32'h0000000C;
    step();
    chk_out("hlt_ins", 0, 10'h000, 32'h0000000C, 1, 0);
    imem_ready = 1'b0;
    step();
`ifdef FETCH_HALT_EN
    chk_out("halt", 0, 10'h000, 32'h0000000C, 1, 1);
    start = 1'b1; imem_ready = 1'b1;
    step();
    chk_out("halt_stay", 0, 10'h000, 32'h0000000C, 1, 1);
`else
    chk_out("no_halt", 1, 10'h004, 32'h0000000C, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter PC_W, default 10, SHALL set the PC and instruction-address width in bits.
REQ-002 Parameter RESET_PC, default 0, SHALL set the PC value loaded at reset.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum FETCH cycles allowed without imem_ready.
REQ-004 Port clk, input, 1, SHALL be the single clock; all state changes occur on its rising edge.
REQ-005 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-006 Port start, input, 1, SHALL request that fetching begin from IDLE.
REQ-007 Port stall, input, 1, SHALL hold the current PC and instruction while high.
REQ-008 Port PCSrc, input, 1, SHALL select the branch target for the next PC.
REQ-009 Port sl2, input, 32, SHALL carry the branch offset, already shifted left by 2.
REQ-010 Port imem_ready, input, 1, SHALL indicate that imem_rdata is valid this cycle.
REQ-011 Port imem_rdata, input, 32, SHALL carry the instruction word returned by memory.
REQ-012 Port imem_req, output, 1, SHALL request an instruction-memory read.
REQ-013 Port imem_addr, output, PC_W, SHALL carry the read address, equal to pc.
REQ-014 Port pc, output, PC_W, SHALL carry the current program counter.
REQ-015 Port ins, output, 32, SHALL carry the latched instruction.
REQ-016 Port ins_valid, output, 1, SHALL be high while ins is valid for the current pc.
REQ-017 Port halted, output, 1, SHALL be high in the ERR or HALT state.

Function
REQ-018 The block SHALL implement the states IDLE, FETCH, HOLD, ERR and, when configured, HALT.
REQ-019 In IDLE, imem_req SHALL be 0; when start=1 the block SHALL move to FETCH on the next edge.
REQ-020 In FETCH, imem_req SHALL be 1 combinationally and imem_addr SHALL equal pc.
REQ-021 In FETCH with imem_ready=1, the block SHALL latch imem_rdata into ins, set ins_valid=1 and move to HOLD on the same edge, giving 1-cycle latency from ready to ins_valid.
REQ-022 A 4-bit wait counter SHALL clear on entry to FETCH and increment each FETCH cycle with imem_ready=0.
REQ-023 When the wait counter reaches TIMEOUT with imem_ready=0, the block SHALL move to ERR.
REQ-024 imem_ready arriving in the same cycle the counter reaches TIMEOUT SHALL take priority over the timeout.
REQ-025 In HOLD with stall=1, pc, ins and ins_valid SHALL hold and PCSrc SHALL be ignored.
REQ-026 In HOLD with stall=0, PCSrc=0: the block SHALL set pc to pc+4, ins_valid to 0 and move to FETCH.
REQ-027 In HOLD with stall=0, PCSrc=1: the block SHALL set pc to pc+4+sl2[PC_W-1:0], ins_valid to 0 and move to FETCH.
REQ-028 All PC arithmetic SHALL be modulo 2^PC_W, with no wrap detection (for example, 0x3FC+4 = 0x000).
REQ-029 PCSrc, sl2 and stall SHALL be ignored outside HOLD; imem_ready SHALL be ignored outside FETCH.
REQ-030 ERR SHALL be terminal until reset, with imem_req=0, halted=1 and ins_valid=0.
REQ-031 start SHALL be ignored outside IDLE.

Reset
REQ-032 While reset=0, regardless of clk, the block SHALL force state=IDLE, pc=RESET_PC, ins=0, ins_valid=0, halted=0, imem_req=0 and wait counter=0.
REQ-033 Reset asserted mid-FETCH SHALL abandon the outstanding request, and imem_ready SHALL be ignored until the block next enters FETCH.
REQ-034 After reset is released, the block SHALL remain in IDLE until start=1 is sampled.

Configuration
REQ-035 With macro FETCH_HALT_EN defined, a latched ins equal to 32'h0000000C in HOLD with stall=0 SHALL move the block to HALT, with pc unchanged, imem_req=0, halted=1 and ins_valid=1, until reset.
REQ-036 Without FETCH_HALT_EN, the HALT state SHALL not exist and 32'h0000000C SHALL be treated as an ordinary instruction.

Verification
REQ-037 The bench SHALL cover: reset low, then high, start=1, imem_ready=1 every FETCH cycle with rdata=0x11111111 -> pc sequence 0,4,8 in successive HOLDs, ins=0x11111111, ins_valid high 1 cycle per HOLD.
REQ-038 The bench SHALL cover: in HOLD at pc=0x010, PCSrc=1, sl2=0x20 -> next FETCH at imem_addr=0x034.
REQ-039 The bench SHALL cover: stall=1 for 3 cycles in HOLD with PCSrc=1 -> pc and ins unchanged, and the branch is not taken unless PCSrc=1 is still present when stall drops.
REQ-040 The bench SHALL cover: imem_ready held 0 in FETCH -> ERR with halted=1 after 15 cycles; ready on cycle 15 -> HOLD instead.
REQ-041 The bench SHALL cover: reset pulsed low mid-FETCH at pc=0x008 -> pc=0, imem_req=0 immediately (asynchronous), and IDLE.
REQ-042 The bench SHALL cover: with FETCH_HALT_EN defined, rdata=0x0000000C -> halted=1, pc frozen; without the macro -> pc advances by 4.
